// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with registered one-hot grant and
// binary grant index (bit i -> index i) for the shared datapath input mux.
// Optional feature macro: HOLD_LIMIT_EN. When it is defined, an owner is
// preempted after MAX_HOLD cycles of tenure if another requester is waiting.
// When it is undefined, tenure is unlimited and the hold counter is not built.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Reject configurations the hold counter cannot represent
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be at least 2");
  end
  if (CNT_W < $clog2(MAX_HOLD)) begin : g_bad_cnt_w
    $error("rr_arbiter4: CNT_W too narrow for MAX_HOLD-1");
  end

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;

`ifdef HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             owner_req;
  logic             others_req;

  // Rotated priority search starting just after the last granted index
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IDX_W'(last_idx_q + IDX_W'(k));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Current owner's request and whether anyone else is competing
  always_comb begin
    owner_req  = req[gnt_idx_q];
    others_req = |(req & ~gnt_q);
  end

  // Next-state and registered output decisions
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    last_idx_d  = last_idx_q;
`ifdef HOLD_LIMIT_EN
    hold_cnt_d  = hold_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d     = ST_GRANT;
          gnt_d       = N_REQ'(4'b0001 << win_idx);
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          last_idx_d  = win_idx;
`ifdef HOLD_LIMIT_EN
          hold_cnt_d  = '0;
`endif
        end
      end

      ST_GRANT: begin
        if (owner_req) begin
`ifdef HOLD_LIMIT_EN
          if ((hold_cnt_q == HOLD_LAST) && others_req) begin
            // Tenure exhausted with a competitor waiting: hand over
            gnt_d       = N_REQ'(4'b0001 << win_idx);
            gnt_idx_d   = win_idx;
            last_idx_d  = win_idx;
            hold_cnt_d  = '0;
          end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d  = hold_cnt_q + CNT_W'(1);
          end
`endif
        end else if (win_found) begin
          // Owner released with others waiting: switch with no idle bubble
          gnt_d       = N_REQ'(4'b0001 << win_idx);
          gnt_idx_d   = win_idx;
          last_idx_d  = win_idx;
`ifdef HOLD_LIMIT_EN
          hold_cnt_d  = '0;
`endif
        end else begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; index 3 as last owner gives requester 0 first turn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      last_idx_q  <= IDX_W'(N_REQ - 1);
`ifdef HOLD_LIMIT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      last_idx_q  <= last_idx_d;
`ifdef HOLD_LIMIT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule
